ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB3 master bridge; the DUT driven by the AHB master agent's interface and observed on its AHB side by the AHB monitor.
- Accepts one AHB transfer at a time and converts it into one APB setup/access sequence.
- Stalls the AHB data phase with hreadyout until the APB side completes.
- Maps pslverr to the AHB two-cycle ERROR response.

Parameters:
- AHB_AW, 32, AHB address width; also the paddr width.
- AHB_DW, 32, AHB/APB data width; only 32 is supported.

Ports:
- clk  in  1  single clock for both AHB and APB sides
- reset  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- haddr  in  AHB_AW  address-phase address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  accepted, ignored
- hready  in  1  bus-level ready (mux output)
- hwdata  in  AHB_DW  data-phase write data
- hrdata  out  AHB_DW  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- paddr  out  AHB_AW  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  AHB_DW  APB write data
- prdata  in  AHB_DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset values (asynchronous assert, state forced immediately):
  - hreadyout=1, hresp=0, hrdata=0
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0
  - state=IDLE
- Accept condition, sampled at a clk edge: hsel & htrans[1] & hready, with state IDLE or ERR2.
- On accept: latch haddr→paddr, hwrite→pwrite, hsize.
  - If hsize>3'b010 go to ERR1.
  - Otherwise go to CAPTURE.
- IDLE/BUSY htrans, or hsel=0: no action; hreadyout=1, hresp=0 (OKAY, zero wait).
- States, all outputs registered:
  - IDLE: hreadyout=1, psel=0.
  - CAPTURE: hreadyout=0. Write: register hwdata→pwdata at the end of this cycle. Read: pwdata holds. Next state SETUP.
  - SETUP: psel=1, penable=0. Next state ACCESS.
  - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable.
    - pready=0: stay in ACCESS (unbounded wait).
    - pready=1 & pslverr=0: read latches prdata→hrdata; go to IDLE with hreadyout=1, hresp=0.
    - pready=1 & pslverr=1: go to ERR1.
  - On any exit from ACCESS: psel=0, penable=0.
  - ERR1: hreadyout=0, hresp=1. Next state ERR2.
  - ERR2: hreadyout=1, hresp=1. A new address phase may be accepted here; otherwise go to IDLE.
- Latency, pready=1 on first ACCESS cycle: address phase at T0; hreadyout low T1–T3; completes at T4 with 3 wait states. Each extra pready=0 cycle adds one.
- Back-to-back: a transfer accepted in the completion cycle (IDLE, hreadyout=1) starts CAPTURE at the next edge with no bubble.
- hrdata holds its last value except on read completion.
- hresp=1 only in ERR1/ERR2.
- An oversize hsize error: no APB access at all (psel never asserts).
- Reset mid-transfer: APB access aborted, pending AHB transfer dropped, all outputs return to reset values.

Decomposition:
- Shared package ahb2apb_pkg holds:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - hresp constants OKAY/ERROR
  - bridge_state_e (IDLE, CAPTURE, SETUP, ACCESS, ERR1, ERR2)
  - HSIZE_WORD = 3'b010
- No sub-module: a single FSM plus datapath registers is natural.

Test Plan:
- Write, haddr=0x0000_1004, hwdata=0xDEAD_BEEF, pready=1 → SETUP at T2 with psel=1, penable=0, paddr=0x1004, pwdata=0xDEADBEEF; ACCESS at T3; hreadyout=1 at T4, hresp=0.
- Read, haddr=0x20, prdata=0x1234_5678, pready low for 3 ACCESS cycles → hreadyout low 6 cycles, then hrdata=0x12345678 with hreadyout=1.
- Write with pslverr=1 & pready=1 → ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE hresp=0.
- hsize=3'b011 NONSEQ → ERR1/ERR2 error pair; psel stays 0 throughout.
- Back-to-back: NONSEQ write 0x40 followed by NONSEQ read 0x44 presented in the write's completion cycle → second CAPTURE starts with no gap; both APB accesses seen in order. htrans=BUSY → no APB activity, hreadyout stays 1.
- Assert reset during ACCESS (pready=0) → psel=0, penable=0, hreadyout=1, hresp=0 immediately, before the next clk edge; the next NONSEQ after deassertion completes normally.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// rtl/ahb2apb_pkg.sv - Shared types and constants for the AHB-Lite to APB3 bridge
//
// Purpose:
//   Holds the AHB transfer-type encoding, response codes, the bridge FSM
//   state encoding and the largest transfer size the bridge forwards to APB.
//   Imported by the bridge top and by the testbench.
//
// Contents:
//   htrans_e        AHB HTRANS encoding (IDLE, BUSY, NONSEQ, SEQ)
//   HRESP_OKAY/ERR  AHB HRESP values
//   bridge_state_e  bridge FSM states
//   HSIZE_WORD      largest hsize that maps onto a 32-bit APB access
//   is_active_trans true for NONSEQ/SEQ, i.e. transfers that need a response

package ahb2apb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } bridge_state_e;

  // Byte, halfword and word fit the 32-bit APB data path; anything wider
  // is refused with an ERROR response.
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// rtl/ahb2apb_bridge_if.sv - AHB-Lite slave side and APB3 master side signal bundle
//
// Purpose:
//   Groups every bus signal of the bridge so the bridge and its environment
//   connect through a single port. The slave modport is the bridge's view;
//   the master modport is the view of whatever drives the AHB requests and
//   answers the APB accesses (AHB master plus APB completer).
//
// Parameters:
//   AW  address width (haddr, paddr)
//   DW  data width (hwdata, hrdata, pwdata, prdata)
//
// Signals:
//   AHB: hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata  (to bridge)
//        hrdata, hreadyout, hresp                                    (from bridge)
//   APB: paddr, psel, penable, pwrite, pwdata                        (from bridge)
//        prdata, pready, pslverr                                     (to bridge)

interface ahb2apb_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hready;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hreadyout;
  logic          hresp;

  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
    output hrdata, hreadyout, hresp,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
    input  hrdata, hreadyout, hresp,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB-Lite slave to APB3 master bridge, one transfer at a time
//
// Purpose:
//   Accepts one AHB-Lite transfer, stalls its data phase with hreadyout and
//   replays it as one APB3 setup/access pair. An APB pslverr, or an AHB size
//   wider than a word, is returned as the two-cycle AHB ERROR response.
//   Every bus output is a flop so both buses see glitch-free signals.
//
// Parameters:
//   AHB_AW  address width, also the paddr width
//   AHB_DW  data width; only 32 is supported
//
// Ports:
//   clk    single clock shared by the AHB and APB sides
//   reset  asynchronous, active-high; aborts any transfer in flight
//   bus    ahb2apb_bridge_if.slave (AHB slave inputs/outputs, APB master
//          outputs/inputs; hburst is accepted and ignored)
//
// Timing for a word transfer with pready high on the first access cycle:
//   T0 address phase, T1 CAPTURE, T2 SETUP, T3 ACCESS, T4 back in IDLE with
//   hreadyout high (three wait states); each pready-low cycle adds one.

module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32
) (
  input  logic             clk,
  input  logic             reset,
  ahb2apb_bridge_if.slave  bus
);

  bridge_state_e state_q, state_d;

  logic [AHB_AW-1:0] paddr_q,  paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [AHB_DW-1:0] pwdata_q, pwdata_d;
  logic [AHB_DW-1:0] hrdata_q, hrdata_d;

  logic hreadyout_q, hreadyout_d;
  logic hresp_q,     hresp_d;
  logic psel_q,      psel_d;
  logic penable_q,   penable_d;

  logic accept;
  logic size_ok;

  // Burst type has no meaning on APB; every beat is handled as a single.
  logic unused_hburst;
  assign unused_hburst = ^bus.hburst;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    // A new address phase can only be taken while the previous data phase
    // is finishing with hreadyout high: plain IDLE or the second ERROR cycle.
    accept  = bus.hsel && bus.hready && is_active_trans(bus.htrans) &&
              ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    size_ok = (bus.hsize <= HSIZE_WORD);

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          state_d = size_ok ? ST_CAPTURE : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // hwdata is only valid in the data phase, one cycle after the address.
      ST_CAPTURE: begin
        if (pwrite_q) begin
          pwdata_d = bus.hwdata;
        end
        state_d = ST_SETUP;
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            state_d = ST_ERR1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = bus.prdata;
            end
            state_d = ST_IDLE;
          end
        end
      end

      ST_ERR1: begin
        state_d = ST_ERR2;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      paddr_d  = bus.haddr;
      pwrite_d = bus.hwrite;
    end

    // Outputs are decoded from the next state so they leave the flops
    // already aligned with the state they describe.
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - Self-checking bench for ahb2apb_bridge

module tb_ahb2apb_bridge;
  import ahb2apb_pkg::*;

  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic reset;
  logic hready_blk;

  always #5 clk = ~clk;

  ahb2apb_bridge_if #(.AW(32), .DW(32)) bus ();

  ahb2apb_bridge #(.AHB_AW(32), .AHB_DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-slave system: the bus-level hready is this slave's hreadyout,
  // optionally pulled low to mimic another slave still stalling.
  assign bus.hready = bus.hreadyout & ~hready_blk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle view of the bridge, filled when a transfer is issued.
  bit          e_rdy  [MAXC];
  bit          e_resp [MAXC];
  bit          e_psel [MAXC];
  bit          e_pen  [MAXC];
  bit          e_pw   [MAXC];
  logic [31:0] e_addr [MAXC];
  logic [31:0] e_wd   [MAXC];
  bit          hv     [MAXC];
  logic [31:0] hd     [MAXC];
  // APB completer responses and AHB write data, scheduled per cycle.
  bit          af     [MAXC];
  bit          ap_rdy [MAXC];
  bit          ap_err [MAXC];
  logic [31:0] ap_dat [MAXC];
  bit          wv     [MAXC];
  logic [31:0] wd     [MAXC];

  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;
  logic [31:0] hrd_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset && cyc < MAXC) begin
      if (hv[cyc]) hrd_model = hd[cyc];
      chk("ctl{hreadyout,hresp,psel,penable}",
          {28'd0, bus.hreadyout, bus.hresp, bus.psel, bus.penable},
          {28'd0, e_rdy[cyc], e_resp[cyc], e_psel[cyc], e_pen[cyc]});
      chk("hrdata", bus.hrdata, hrd_model);
      if (e_psel[cyc]) begin
        chk("paddr", bus.paddr, e_addr[cyc]);
        chk("pwrite", {31'd0, bus.pwrite}, {31'd0, e_pw[cyc]});
        if (e_pw[cyc]) chk("pwdata", bus.pwdata, e_wd[cyc]);
      end
    end
  end

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_rdy[c] = 1'b1; e_resp[c] = 1'b0; e_psel[c] = 1'b0; e_pen[c] = 1'b0;
      e_pw[c] = 1'b0; e_addr[c] = '0; e_wd[c] = '0; hv[c] = 1'b0; hd[c] = '0;
      af[c] = 1'b0; ap_rdy[c] = 1'b0; ap_err[c] = 1'b0; ap_dat[c] = '0;
      wv[c] = 1'b0; wd[c] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc < MAXC && af[cyc]) begin
      bus.pready = ap_rdy[cyc]; bus.pslverr = ap_err[cyc]; bus.prdata = ap_dat[cyc];
    end else begin
      bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
    end
    bus.hwdata = (cyc < MAXC && wv[cyc]) ? wd[cyc] : $urandom;
  endtask

  // Non-accepting address-phase patterns: 0 unselected NONSEQ, 1 IDLE,
  // 2 BUSY, 3 NONSEQ while the bus-level hready is held low.
  task automatic idle_pat(input int kind);
    bus.haddr = $urandom; bus.hwrite = 1'($urandom); bus.hsize = 3'($urandom);
    bus.hburst = 3'($urandom); hready_blk = 1'b0;
    case (kind)
      0:       begin bus.hsel = 1'b0; bus.htrans = HT_NONSEQ; end
      1:       begin bus.hsel = 1'b1; bus.htrans = HT_IDLE;   end
      2:       begin bus.hsel = 1'b1; bus.htrans = HT_BUSY;   end
      default: begin bus.hsel = 1'b1; bus.htrans = HT_NONSEQ; hready_blk = 1'b1; end
    endcase
  endtask

  task automatic step_stall();
    step();
    bus.hsel = 1'($urandom); bus.htrans = HT_IDLE; bus.haddr = $urandom;
    hready_blk = 1'b0;
  endtask

  task automatic run_to(input int d);
    while (cyc < d) step_stall();
  endtask

  // Presents one address phase in the current cycle and records what the
  // bridge must do in the following cycles. d is hwdata for writes and the
  // completer's prdata for reads; w is the number of pready-low access cycles.
  task automatic issue(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                       input logic [31:0] d, input int w, input bit err,
                       input bit seq, output int done);
    int t0;
    t0 = cyc;
    bus.hsel = 1'b1; bus.htrans = seq ? HT_SEQ : HT_NONSEQ; bus.haddr = a;
    bus.hwrite = wr; bus.hsize = sz; bus.hburst = 3'($urandom); hready_blk = 1'b0;
    if (sz > HSIZE_WORD) begin
      e_rdy[t0+1] = 1'b0; e_resp[t0+1] = 1'b1; e_resp[t0+2] = 1'b1;
      wv[t0+1] = 1'b1; wd[t0+1] = d;
      done = t0 + 2;
    end else begin
      for (int c = t0 + 1; c <= t0 + 3 + w; c++) e_rdy[c] = 1'b0;
      for (int c = t0 + 2; c <= t0 + 3 + w; c++) begin
        e_psel[c] = 1'b1; e_addr[c] = a; e_pw[c] = wr; e_wd[c] = d;
      end
      for (int c = t0 + 3; c <= t0 + 3 + w; c++) begin
        e_pen[c] = 1'b1; af[c] = 1'b1; ap_rdy[c] = 1'b0;
        ap_err[c] = 1'($urandom); ap_dat[c] = $urandom;
      end
      ap_rdy[t0+3+w] = 1'b1; ap_err[t0+3+w] = err; ap_dat[t0+3+w] = wr ? $urandom : d;
      if (err) begin
        e_rdy[t0+4+w] = 1'b0; e_resp[t0+4+w] = 1'b1; e_resp[t0+5+w] = 1'b1;
        done = t0 + 5 + w;
      end else begin
        done = t0 + 4 + w;
        if (!wr) begin hv[done] = 1'b1; hd[done] = d; end
      end
      for (int c = t0 + 1; c < done; c++) begin wv[c] = wr; wd[c] = d; end
    end
  endtask

  initial begin
    int t0, done, lowcnt, gap, w;
    bit wr, err;
    logic [2:0] sz;
    logic [31:0] a, d;

    reset = 1'b0; hready_blk = 1'b0;
    bus.hsel = 1'b0; bus.htrans = HT_IDLE; bus.haddr = '0; bus.hwrite = 1'b0;
    bus.hsize = HSIZE_WORD; bus.hburst = '0; bus.hwdata = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    clear_from(0);
    #1 reset = 1'b1;
    #1;
    chk("reset ctl", {28'd0, bus.hreadyout, bus.hresp, bus.psel, bus.penable}, 32'h8);
    chk("reset hrdata", bus.hrdata, 32'h0);
    chk("reset paddr", bus.paddr, 32'h0);
    chk("reset pwdata", bus.pwdata, 32'h0);
    chk("reset pwrite", {31'd0, bus.pwrite}, 32'h0);
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Write 0x1004 <- 0xDEADBEEF, pready on the first access cycle.
    issue(32'h0000_1004, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, done);
    t0 = cyc;
    step_stall();
    chk("wr T1 hreadyout", {31'd0, bus.hreadyout}, 32'd0);
    step_stall();
    chk("wr T2 psel/penable", {30'd0, bus.psel, bus.penable}, 32'h2);
    chk("wr T2 paddr", bus.paddr, 32'h0000_1004);
    chk("wr T2 pwdata", bus.pwdata, 32'hDEAD_BEEF);
    chk("wr T2 pwrite", {31'd0, bus.pwrite}, 32'd1);
    step_stall();
    chk("wr T3 psel/penable", {30'd0, bus.psel, bus.penable}, 32'h3);
    step_stall();
    chk("wr T4 hreadyout/hresp", {30'd0, bus.hreadyout, bus.hresp}, 32'h2);
    run_to(done);

    // Read 0x20 with three pready-low access cycles.
    issue(32'h20, 1'b0, HSIZE_WORD, 32'h1234_5678, 3, 1'b0, 1'b0, done);
    lowcnt = 0;
    for (int k = 0; k < 12; k++) begin
      step_stall();
      if (bus.hreadyout === 1'b1) break;
      lowcnt++;
    end
    chk("rd wait states", lowcnt, 32'd6);
    chk("rd hrdata", bus.hrdata, 32'h1234_5678);
    run_to(done);

    // Write answered with pslverr.
    issue(32'h300, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, 1, 1'b1, 1'b0, done);
    t0 = cyc;
    run_to(t0 + 5);
    chk("err ERR1", {30'd0, bus.hreadyout, bus.hresp}, 32'h1);
    step_stall();
    chk("err ERR2", {30'd0, bus.hreadyout, bus.hresp}, 32'h3);
    step_stall();
    chk("err back to IDLE", {30'd0, bus.hreadyout, bus.hresp}, 32'h2);

    // Oversize transfer: error pair, no APB access.
    issue(32'h400, 1'b0, 3'b011, 32'h0, 0, 1'b0, 1'b0, done);
    step_stall();
    chk("size ERR1", {29'd0, bus.hreadyout, bus.hresp, bus.psel}, 32'h2);
    step_stall();
    chk("size ERR2", {29'd0, bus.hreadyout, bus.hresp, bus.psel}, 32'h6);
    step_stall();
    chk("size IDLE", {29'd0, bus.hreadyout, bus.hresp, bus.psel}, 32'h4);

    // Back-to-back write 0x40 then read 0x44 issued in the completion cycle.
    issue(32'h40, 1'b1, HSIZE_WORD, 32'hCAFE_0040, 0, 1'b0, 1'b0, done);
    step_stall(); step_stall();
    chk("b2b first paddr", bus.paddr, 32'h40);
    run_to(done);
    issue(32'h44, 1'b0, HSIZE_WORD, 32'h5555_0044, 0, 1'b0, 1'b0, done);
    step_stall();
    chk("b2b no bubble", {31'd0, bus.hreadyout}, 32'd0);
    step_stall();
    chk("b2b second paddr", bus.paddr, 32'h44);
    chk("b2b second pwrite", {31'd0, bus.pwrite}, 32'd0);
    run_to(done);
    for (int k = 0; k < 3; k++) begin
      idle_pat(2);
      step();
      chk("busy no activity", {30'd0, bus.hreadyout, bus.psel}, 32'h2);
    end

    // Reset while the access is stretched by pready low.
    issue(32'h80, 1'b0, HSIZE_WORD, 32'h7777_0080, 10, 1'b0, 1'b0, done);
    t0 = cyc;
    run_to(t0 + 4);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst ctl", {28'd0, bus.hreadyout, bus.hresp, bus.psel, bus.penable}, 32'h8);
    chk("rst hrdata", bus.hrdata, 32'h0);
    chk("rst paddr", bus.paddr, 32'h0);
    chk("rst pwdata", bus.pwdata, 32'h0);
    step_stall();
    reset = 1'b0;
    clear_from(cyc);
    hrd_model = 32'h0;
    chk_en = 1'b1;
    issue(32'h500, 1'b1, HSIZE_WORD, 32'hA5A5_0001, 2, 1'b0, 1'b0, done);
    run_to(done);
    chk("post-rst done", {30'd0, bus.hreadyout, bus.hresp}, 32'h2);
    chk("post-rst pwdata", bus.pwdata, 32'hA5A5_0001);

    // Randomised traffic.
    for (int n = 0; n < 300 && cyc < MAXC - 64; n++) begin
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
      for (int g = 0; g < gap; g++) begin
        idle_pat(int'($urandom_range(0, 3)));
        step();
      end
      a   = $urandom;
      wr  = 1'($urandom);
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      d   = $urandom;
      w   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      err = ($urandom_range(0, 5) == 0);
      issue(a, wr, sz, d, w, err, 1'($urandom_range(0, 3) == 0), done);
      run_to(done);
    end

    idle_pat(1);
    step(); step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
